lut_access_arbiter: RTL and testbench

//  Shares one single-port voice-effect LUT RAM (1024x16, 1-cycle read, no output reg) between two requesters.

---
 rtl/lut_access_arbiter_pkg.sv | 15 +
 rtl/lut_access_arbiter_if.sv | 33 +++
 rtl/lut_access_arbiter_starve_cnt.sv | 36 +++
 rtl/lut_access_arbiter.sv | 122 ++++++++++++
 tb/tb_lut_access_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lut_access_arbiter_pkg.sv
// Shared types and defaults for the voice-effect LUT access arbiter.
package lut_arb_pkg;

  localparam int unsigned LUT_AW       = 10;
  localparam int unsigned LUT_DW       = 16;
  localparam int unsigned LUT_MAX_WAIT = 8;
  localparam int unsigned WAIT_W       = 8;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    VRD  = 2'd1,
    VCHK = 2'd2
  } arb_state_e;

endpackage

// File: rtl/lut_access_arbiter_if.sv
// Requester A (read), requester B (write) and LUT RAM port signals of the arbiter.
interface lut_access_arbiter_if #(
  parameter int unsigned AW = lut_arb_pkg::LUT_AW,
  parameter int unsigned DW = lut_arb_pkg::LUT_DW
);
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_vld;
  logic [DW-1:0] rd_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_wr_en;
  logic [DW-1:0] ram_rd_data;
  logic          err_clr;
  logic          verify_err;

  // Arbiter side
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_rd_data, err_clr,
    output rd_gnt, rd_vld, rd_data, wr_gnt, ram_addr, ram_wr_data, ram_wr_en, verify_err
  );

  // Requester / RAM side
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_rd_data, err_clr,
    input  rd_gnt, rd_vld, rd_data, wr_gnt, ram_addr, ram_wr_data, ram_wr_en, verify_err
  );
endinterface

// File: rtl/lut_access_arbiter_starve_cnt.sv
// Saturating wait counter for the write requester; force_c asks for a forced write grant.
module lut_starve_cnt
  import lut_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = LUT_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              gnt,
  input  logic              hold,
  output logic              force_c,
  output logic [WAIT_W-1:0] cnt_q
);

  logic [WAIT_W-1:0] cnt_d;

  // Count while the writer waits, clear when it is served or goes idle
  always_comb begin
    cnt_d = cnt_q;
    if (!req || gnt) begin
      cnt_d = '0;
    end else if (!hold && (cnt_q != WAIT_W'(MAX_WAIT))) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign force_c = (cnt_q == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/lut_access_arbiter.sv
// Single-port LUT RAM arbiter: fixed-priority reader, starvation-guarded writer.
// Optional write-verify read-back enabled by defining LUT_WR_VERIFY_EN.
// AW/DW must match the widths of the connected interface instance.
module lut_access_arbiter
  import lut_arb_pkg::*;
#(
  parameter int unsigned AW       = LUT_AW,
  parameter int unsigned DW       = LUT_DW,
  parameter int unsigned MAX_WAIT = LUT_MAX_WAIT
) (
  input logic                  clk,
  input logic                  rst,
  lut_access_arbiter_if.slave  bus
);

  arb_state_e        state_q, state_d;
  logic              rd_gnt_c, wr_gnt_c, force_c, hold_c;
  logic              rd_vld_q, rd_vld_d;
  logic              verify_err_q, verify_err_d;
  logic [AW-1:0]     ram_addr_c;
  logic [DW-1:0]     ram_wr_data_c;
  logic [WAIT_W-1:0] wait_cnt;

`ifdef LUT_WR_VERIFY_EN
  logic [AW-1:0] lat_addr_q, lat_addr_d;
  logic [DW-1:0] lat_data_q, lat_data_d;
  logic          mismatch_c;
`else
  logic          unused_err_clr;
  assign unused_err_clr = bus.err_clr;
`endif

  lut_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.wr_req),
    .gnt     (wr_gnt_c),
    .hold    (hold_c),
    .force_c (force_c),
    .cnt_q   (wait_cnt)
  );

  // Grant mux, RAM address select, FSM next state and verify flag
  always_comb begin
    state_d       = state_q;
    rd_gnt_c      = 1'b0;
    wr_gnt_c      = 1'b0;
    hold_c        = 1'b0;
    ram_wr_data_c = bus.wr_data;
    verify_err_d  = verify_err_q;
`ifdef LUT_WR_VERIFY_EN
    lat_addr_d    = lat_addr_q;
    lat_data_d    = lat_data_q;
    mismatch_c    = 1'b0;
`endif

    if (!rst && (state_q != VRD)) begin
      if (bus.wr_req && (!bus.rd_req || force_c)) wr_gnt_c = 1'b1;
      else if (bus.rd_req)                        rd_gnt_c = 1'b1;
    end
    ram_addr_c = wr_gnt_c ? bus.wr_addr : bus.rd_addr;

`ifdef LUT_WR_VERIFY_EN
    case (state_q)
      ARB:  if (wr_gnt_c) state_d = VRD;
      VRD: begin
        hold_c     = 1'b1;
        ram_addr_c = lat_addr_q;
        state_d    = VCHK;
      end
      VCHK: begin
        mismatch_c = (bus.ram_rd_data != lat_data_q);
        state_d    = wr_gnt_c ? VRD : ARB;
      end
      default: state_d = ARB;
    endcase
    if (wr_gnt_c) begin
      lat_addr_d = bus.wr_addr;
      lat_data_d = bus.wr_data;
    end
    // A new mismatch overrides a simultaneous clear
    if (mismatch_c)       verify_err_d = 1'b1;
    else if (bus.err_clr) verify_err_d = 1'b0;
`else
    state_d      = ARB;
    verify_err_d = 1'b0;
`endif

    rd_vld_d = rd_gnt_c;
  end

  // State, read-valid and error flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB;
      rd_vld_q     <= 1'b0;
      verify_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_vld_q     <= rd_vld_d;
      verify_err_q <= verify_err_d;
    end
  end

`ifdef LUT_WR_VERIFY_EN
  // Latched write address/data for the read-back compare
  always_ff @(posedge clk) begin
    lat_addr_q <= lat_addr_d;
    lat_data_q <= lat_data_d;
  end
`endif

  assign bus.rd_gnt      = rd_gnt_c;
  assign bus.wr_gnt      = wr_gnt_c;
  assign bus.rd_vld      = rd_vld_q;
  assign bus.rd_data     = bus.ram_rd_data;
  assign bus.ram_addr    = ram_addr_c;
  assign bus.ram_wr_data = ram_wr_data_c;
  assign bus.ram_wr_en   = wr_gnt_c;
  assign bus.verify_err  = verify_err_q;

endmodule

// File: tb/tb_lut_access_arbiter.sv
// Scoreboard bench for lut_access_arbiter with a behavioural 1024x16 LUT RAM.
module tb_lut_access_arbiter;
  import lut_arb_pkg::*;

  localparam int unsigned MAXW = 8;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  lut_access_arbiter_if #(.AW(LUT_AW), .DW(LUT_DW)) bus ();

  lut_access_arbiter #(.AW(LUT_AW), .DW(LUT_DW), .MAX_WAIT(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: 1-cycle read, write-through on the written address
  logic [15:0] mem   [0:1023];
  logic [15:0] model [0:1023];
  logic [15:0] ram_q;
  logic        corrupt;

  always @(posedge clk) begin
    if (bus.ram_wr_en) mem[bus.ram_addr] <= bus.ram_wr_data;
    ram_q <= bus.ram_wr_en ? bus.ram_wr_data : mem[bus.ram_addr];
  end
  assign bus.ram_rd_data = ram_q ^ (corrupt ? 16'hFFFF : 16'h0000);

  logic [15:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read results popped from the scoreboard as rd_vld arrives
  always @(negedge clk) begin
    if (bus.rd_vld === 1'b1) begin
      if (exp_q.size() == 0) check("rd_vld_unexpected", 32'd1, 32'd0);
      else                   check("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic do_read(input logic [9:0] addr);
    bit got;
    got = 1'b0;
    bus.rd_addr = addr;
    bus.rd_req  = 1'b1;
    exp_q.push_back(model[addr]);
    for (int k = 0; k < 16 && !got; k++) begin
      @(negedge clk);
      if (bus.rd_gnt === 1'b1) got = 1'b1;
      else                     step();
    end
    check("rd_gnt_wait", 32'(got), 32'd1);
    if (!got) void'(exp_q.pop_back());
    step();
    bus.rd_req = 1'b0;
  endtask

  task automatic write_once(input logic [9:0] addr, input logic [15:0] data);
    bus.wr_addr = addr;
    bus.wr_data = data;
    bus.wr_req  = 1'b1;
    @(negedge clk);
    check("v_wr_gnt", 32'(bus.wr_gnt), 32'd1);
    model[addr] = data;
    step();
    bus.wr_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]   = 16'(i * 3 + 7);
      model[i] = 16'(i * 3 + 7);
    end
    mem[5]   = 16'h1234;
    model[5] = 16'h1234;
    corrupt  = 1'b0;

    // Reset with both requesters active
    rst = 1'b1;
    bus.rd_req = 1'b1; bus.wr_req = 1'b1; bus.err_clr = 1'b0;
    bus.rd_addr = '0; bus.wr_addr = '0; bus.wr_data = '0;
    step();
    repeat (3) begin
      @(negedge clk);
      check("rst_rd_gnt",     32'(bus.rd_gnt),     32'd0);
      check("rst_wr_gnt",     32'(bus.wr_gnt),     32'd0);
      check("rst_ram_wr_en",  32'(bus.ram_wr_en),  32'd0);
      check("rst_rd_vld",     32'(bus.rd_vld),     32'd0);
      check("rst_verify_err", 32'(bus.verify_err), 32'd0);
      step();
    end
    bus.rd_req = 1'b0; bus.wr_req = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("rst_state",    32'(dut.state_q),  32'(ARB));
    check("rst_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    step();

    // Read latency: grant at T, data at T+1
    bus.rd_addr = 10'h005; bus.rd_req = 1'b1;
    exp_q.push_back(model[10'h005]);
    @(negedge clk);
    check("lat_rd_gnt", 32'(bus.rd_gnt), 32'd1);
    step();
    bus.rd_req = 1'b0;
    @(negedge clk);
    check("lat_rd_vld", 32'(bus.rd_vld), 32'd1);
    step();

    // Four back-to-back reads
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = 10'(8 + i); bus.rd_req = 1'b1;
      exp_q.push_back(model[8 + i]);
      @(negedge clk);
      check("b2b_rd_gnt", 32'(bus.rd_gnt), 32'd1);
      if (i > 0) check("b2b_rd_vld", 32'(bus.rd_vld), 32'd1);
      step();
    end
    bus.rd_req = 1'b0;
    @(negedge clk);
    check("b2b_last_vld", 32'(bus.rd_vld), 32'd1);
    step();
    @(negedge clk);
    check("b2b_idle_vld", 32'(bus.rd_vld), 32'd0);
    step();

    // Starvation guard: writer forced in after MAXW cycles
    bus.rd_addr = 10'h010; bus.rd_req = 1'b1;
    bus.wr_addr = 10'h3FF; bus.wr_data = 16'hBEEF; bus.wr_req = 1'b1;
    for (int c = 0; c <= int'(MAXW); c++) begin
      @(negedge clk);
      if (c < int'(MAXW)) begin
        check("starve_rd_gnt", 32'(bus.rd_gnt), 32'd1);
        check("starve_wr_wait", 32'(bus.wr_gnt), 32'd0);
        exp_q.push_back(model[10'h010]);
      end else begin
        check("starve_wr_gnt",   32'(bus.wr_gnt),    32'd1);
        check("starve_rd_block", 32'(bus.rd_gnt),    32'd0);
        check("starve_ram_addr", 32'(bus.ram_addr),  32'h3FF);
        check("starve_wr_en",    32'(bus.ram_wr_en), 32'd1);
        model[10'h3FF] = 16'hBEEF;
      end
      step();
    end
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    @(negedge clk);
    check("starve_wait_clr", 32'(dut.wait_cnt), 32'd0);
    step();
    do_read(10'h3FF);

    // Idle reader: sequential writes, then read back
    bus.wr_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.wr_addr = 10'(i);
      bus.wr_data = 16'(16'hA500 + i);
      @(negedge clk);
      check("seq_wr_gnt",   32'(bus.wr_gnt),   32'd1);
      check("seq_ram_addr", 32'(bus.ram_addr), 32'(i));
      model[i] = 16'(16'hA500 + i);
      step();
`ifdef LUT_WR_VERIFY_EN
      @(negedge clk);
      check("seq_vrd_no_gnt", 32'(bus.wr_gnt), 32'd0);
      step();
`endif
    end
    bus.wr_req = 1'b0;
    for (int i = 0; i < 16; i++) do_read(10'(i));

    // Reset in the same cycle as a read request drops the read
    rst = 1'b1; bus.rd_addr = 10'h020; bus.rd_req = 1'b1;
    @(negedge clk);
    check("rstrd_rd_gnt", 32'(bus.rd_gnt), 32'd0);
    step();
    rst = 1'b0; bus.rd_req = 1'b0;
    @(negedge clk);
    check("rstrd_rd_vld", 32'(bus.rd_vld), 32'd0);
    step();

`ifdef LUT_WR_VERIFY_EN
    // Write-verify: corrupted read-back sets the sticky flag
    write_once(10'h020, 16'h5A5A);
    @(negedge clk);
    check("v_state_vrd", 32'(dut.state_q),  32'(VRD));
    check("v_ram_addr",  32'(bus.ram_addr), 32'h020);
    check("v_vrd_rdgnt", 32'(bus.rd_gnt),   32'd0);
    step();
    corrupt = 1'b1;
    step();
    corrupt = 1'b0;
    @(negedge clk);
    check("v_err_set", 32'(bus.verify_err), 32'd1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    @(negedge clk);
    check("v_err_clr", 32'(bus.verify_err), 32'd0);
    step();

    // Clean read-back leaves the flag clear
    write_once(10'h021, 16'h0F0F);
    step();
    step();
    @(negedge clk);
    check("v_clean", 32'(bus.verify_err), 32'd0);
    step();

    // Mismatch and clear in the same cycle: set wins
    write_once(10'h022, 16'h3C3C);
    step();
    corrupt = 1'b1; bus.err_clr = 1'b1;
    step();
    corrupt = 1'b0; bus.err_clr = 1'b0;
    @(negedge clk);
    check("v_set_wins", 32'(bus.verify_err), 32'd1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;

    // Reset while in VRD abandons the verify
    write_once(10'h030, 16'h1111);
    corrupt = 1'b1; rst = 1'b1;
    step();
    corrupt = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("vrst_state", 32'(dut.state_q),    32'(ARB));
    check("vrst_vld",   32'(bus.rd_vld),     32'd0);
    check("vrst_err",   32'(bus.verify_err), 32'd0);
    step();
    step();
    @(negedge clk);
    check("vrst_err_after", 32'(bus.verify_err), 32'd0);
    step();
    do_read(10'h022);
`endif

    repeat (3) step();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
